reduction_modulo: RTL and testbench

REDUCTION_MODULO -- requirements
Module: reduction_modulo

---
 rtl/reduction_modulo.sv | 140 ++++++++++++++
 tb/tb_reduction_modulo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_modulo.sv
// reduction_modulo
//   Computes number mod m with a restoring shift-subtract loop, one dividend
//   bit per clock, MSB first. A start in IDLE latches the operands. Finished
//   results appear on registered outputs together with a one-cycle done
//   pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request pulse, sampled only in IDLE
//   number       unsigned dividend, latched on an accepted start
//   m            unsigned modulus, latched on an accepted start
//   result       registered remainder; holds until the next completion
//   busy         high while the FSM is in CALC
//   done         one-cycle completion pulse; result/div_by_zero valid with it
//   div_by_zero  registered flag, set by a completion with m == 0
module reduction_modulo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] num_q;    // dividend, shifted left as bits are consumed
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   rem_q;    // one extra bit so m >= 2^(WIDTH-1) cannot overflow
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_step;
    logic             last_step;

    // After each restoring step the remainder is below m, so the MSB of the
    // stored value is always zero; only the shifted value uses the full width.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    always_comb begin
        rem_sh    = {rem_q[WIDTH-1:0], num_q[WIDTH-1]};
        rem_step  = (rem_sh >= {1'b0, m_q}) ? (rem_sh - {1'b0, m_q}) : rem_sh;
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (m != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q <= '0;
            m_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q <= number;
                        m_q   <= m;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    num_q <= num_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers. busy tracks the CALC state exactly; done/result/flag
    // are loaded from the DONE state, so they appear one edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nx == CALC);
            done <= (state == DONE);
            if (state == IDLE && start && m != '0) begin
                div_by_zero <= 1'b0;
            end
            if (state == DONE) begin
                result      <= (m_q == '0) ? '0 : rem_q[WIDTH-1:0];
                div_by_zero <= (m_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_reduction_modulo.sv
module tb_reduction_modulo;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] number;
    logic [31:0] m;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int unsigned vecs;
    int unsigned errs;

    reduction_modulo #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .number      (number),
        .m           (m),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic remainder, zero for a zero modulus.
    function automatic logic [31:0] ref_mod(input logic [31:0] n, input logic [31:0] d);
        return (d == 32'd0) ? 32'd0 : (n % d);
    endfunction

    // Issue one operation from IDLE and check latency, result, flag and
    // that done is a single-cycle pulse. Operand inputs are scrambled right
    // after acceptance to show they are not re-sampled.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input string tag);
        logic [31:0] exp_r;
        logic        exp_z;
        int          exp_lat;
        int          edges;
        exp_r   = ref_mod(n, d);
        exp_z   = (d == 32'd0);
        exp_lat = (d == 32'd0) ? 2 : 34;
        @(negedge clk);
        number = n;
        m      = d;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        number = $urandom;
        m      = $urandom;
        edges  = 1;
        if (d != 32'd0) begin
            vecs++;
            if (busy !== 1'b1) begin
                errs++;
                $display("FAIL %s busy: got %b want 1", tag, busy);
            end
        end
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        vecs++;
        if (edges !== exp_lat) begin
            errs++;
            $display("FAIL %s latency: got %0d edges want %0d", tag, edges, exp_lat);
        end
        vecs++;
        if (result !== exp_r) begin
            errs++;
            $display("FAIL %s result: n=%h m=%h got %h want %h", tag, n, d, result, exp_r);
        end
        vecs++;
        if (div_by_zero !== exp_z) begin
            errs++;
            $display("FAIL %s div_by_zero: got %b want %b", tag, div_by_zero, exp_z);
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL %s busy at done: got %b want 0", tag, busy);
        end
        @(posedge clk);
        #1;
        vecs++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL %s done width: got %b want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        number = 32'd0;
        m      = 32'd0;
        #2;  // before any clock edge: reset alone must clear the outputs
        vecs++;
        if (result !== 32'd0) begin errs++; $display("FAIL reset result: got %h want 0", result); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", busy); end
        vecs++;
        if (done !== 1'b0) begin errs++; $display("FAIL reset done: got %b want 0", done); end
        vecs++;
        if (div_by_zero !== 1'b0) begin errs++; $display("FAIL reset dbz: got %b want 0", div_by_zero); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(32'd13, 32'd3, "d13m3");
        run_op(32'hFFFF_FFFF, 32'h8000_0001, "dbigm");
        run_op(32'd5, 32'd9, "dlt");
        run_op(32'd0, 32'd7, "dzero");
        run_op(32'd7, 32'd7, "deq");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax");
        run_op(32'hFFFF_FFFF, 32'd1, "dm1");
    endtask

    task automatic test_div_by_zero();
        run_op(32'd100, 32'd0, "z100");
        // flag must persist through idle cycles
        repeat (5) @(posedge clk);
        #1;
        vecs++;
        if (div_by_zero !== 1'b1 || result !== 32'd0) begin
            errs++;
            $display("FAIL zhold: got dbz=%b res=%h want dbz=1 res=0", div_by_zero, result);
        end
        run_op(32'd100, 32'd7, "z100m7");
    endtask

    task automatic test_ignore_start();
        int pulses;
        int first;
        logic [31:0] res;
        pulses = 0;
        first  = 0;
        res    = 32'd0;
        @(negedge clk);
        number = 32'd13;
        m      = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin
                start  = 1'b1;
                number = 32'd50;
                m      = 32'd8;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    res   = result;
                end
            end
        end
        vecs++;
        if (pulses !== 1) begin errs++; $display("FAIL ign pulses: got %0d want 1", pulses); end
        vecs++;
        if (first !== 34) begin errs++; $display("FAIL ign latency: got %0d want 34", first); end
        vecs++;
        if (res !== 32'd1) begin errs++; $display("FAIL ign result: got %h want 1", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] n1, m1, n2, m2, r1, r2;
        int edges, d1, d2;
        n1 = $urandom;
        m1 = $urandom_range(1, 1000);
        n2 = $urandom;
        m2 = $urandom | 32'h8000_0000;
        r1 = 32'd0;
        r2 = 32'd0;
        d1 = 0;
        d2 = 0;
        @(negedge clk);
        number = n1;
        m      = m1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        number = n2;
        m      = m2;
        edges  = 1;
        while (d2 == 0 && edges < 150) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = edges;
                    r1 = result;
                end else begin
                    d2    = edges;
                    r2    = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        vecs++;
        if (d1 !== 34) begin errs++; $display("FAIL b2b first latency: got %0d want 34", d1); end
        vecs++;
        if (d2 !== 68) begin errs++; $display("FAIL b2b second latency: got %0d want 68", d2); end
        vecs++;
        if (r1 !== ref_mod(n1, m1)) begin errs++; $display("FAIL b2b r1: got %h want %h", r1, ref_mod(n1, m1)); end
        vecs++;
        if (r2 !== ref_mod(n2, m2)) begin errs++; $display("FAIL b2b r2: got %h want %h", r2, ref_mod(n2, m2)); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int spurious;
        run_op(32'd14, 32'd9, "preabort");  // leaves a nonzero result behind
        @(negedge clk);
        number = 32'd1000;
        m      = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL abort busy before: got %b want 1", busy); end
        rst = 1'b1;
        #1;  // no clock edge in between
        vecs++;
        if (result !== 32'd0) begin errs++; $display("FAIL abort result: got %h want 0", result); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL abort busy: got %b want 0", busy); end
        vecs++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            errs++;
            $display("FAIL abort flags: got done=%b dbz=%b want 0 0", done, div_by_zero);
        end
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        vecs++;
        if (spurious !== 0) begin errs++; $display("FAIL abort quiet: got %0d active cycles want 0", spurious); end
        run_op(32'd1000, 32'd7, "postabort");
    endtask

    task automatic test_random();
        logic [31:0] n, d;
        for (int i = 0; i < 1000; i++) begin
            n = $urandom;
            case ($urandom_range(0, 3))
                0: d = $urandom_range(1, 255);
                1: d = $urandom | 32'h8000_0000;
                2: begin
                    d = $urandom;
                    if (d == 32'd0) d = 32'd1;
                    n = n % d;  // dividend below modulus
                end
                default: begin
                    d = $urandom;
                    if (d == 32'd0) d = 32'd3;
                end
            endcase
            run_op(n, d, "rand");
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
